// File: rtl/absorb_stage.sv
// absorb_stage: packs a little-endian message stream into rate-sized blocks,
// applies SHAKE padding (0x1F domain byte, 0x80 final bit) and hands each
// block, tagged with a last-block flag, to the permutation core.
module absorb_stage #(
  parameter int WIDTH = 64,
  parameter int RATE  = 1344
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        operation_mode,
  input  logic [31:0]       msg_len,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [RATE-1:0]   block_out,
  output logic              block_valid,
  input  logic              block_ready,
  output logic              last_block,
  output logic              busy
);

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

  typedef enum logic [1:0] {IDLE, FILL, PAD, EMIT} state_t;

  state_t            state;
  logic [31:0]       remaining;
  logic [4:0]        word_idx;
  logic [7:0]        blk_bytes;
  logic [4:0]        depth;
  logic [RATE-1:0]   buffer;
  logic              last_q;

  logic [7:0]        rate_bytes;
  logic [3:0]        take;
  logic [31:0]       new_rem;
  logic [7:0]        new_bb;
  logic [WIDTH-1:0]  fill_word;
  logic [RATE-1:0]   pad_buf;
  logic [10:0]       pad_lo;
  logic [10:0]       end_lo;

  assign rate_bytes    = {depth, 3'b000};
  assign data_in_ready = (state == FILL);
  assign block_valid   = (state == EMIT);
  assign busy          = (state != IDLE);
  assign block_out     = buffer;
  assign last_block    = last_q;

  // Byte accounting for the word currently offered on data_in
  always_comb begin
    take      = (remaining < 32'd8) ? remaining[3:0] : 4'd8;
    new_rem   = remaining - {28'b0, take};
    new_bb    = blk_bytes + {4'b0, take};
    fill_word = '0;
    for (int unsigned j = 0; j < WIDTH / 8; j++) begin
      if (j < remaining) fill_word[8*j +: 8] = data_in[8*j +: 8];
    end
  end

  // Padded image of the buffer; both XORs compose to 0x9F on a shared byte
  always_comb begin
    pad_lo  = {blk_bytes, 3'b000};
    end_lo  = {rate_bytes - 8'd1, 3'b000};
    pad_buf = buffer;
    pad_buf[pad_lo +: 8] = pad_buf[pad_lo +: 8] ^ 8'h1F;
    pad_buf[end_lo +: 8] = pad_buf[end_lo +: 8] ^ 8'h80;
  end

  // Control FSM, counters and block buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      word_idx  <= '0;
      blk_bytes <= '0;
      depth     <= 5'd21;
      buffer    <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            depth     <= (operation_mode == SHAKE256_MODE_VEC) ? 5'd17 : 5'd21;
            remaining <= msg_len;
            word_idx  <= '0;
            blk_bytes <= '0;
            buffer    <= '0;
            last_q    <= 1'b0;
            state     <= (msg_len == 32'd0) ? PAD : FILL;
          end
        end
        FILL: begin
          if (data_in_valid) begin
            buffer[{word_idx, 6'b000000} +: WIDTH] <= fill_word;
            remaining <= new_rem;
            blk_bytes <= new_bb;
            word_idx  <= word_idx + 5'd1;
            // A block is only emitted unpadded when it holds rate_bytes of
            // message; a short final word in the last slot still gets padded
            // in place rather than spilling padding into a new block.
            if (new_bb == rate_bytes) begin
              last_q <= 1'b0;
              state  <= EMIT;
            end else if (new_rem == 32'd0) begin
              state  <= PAD;
            end
          end
        end
        PAD: begin
          buffer <= pad_buf;
          last_q <= 1'b1;
          state  <= EMIT;
        end
        EMIT: begin
          if (block_ready) begin
            buffer    <= '0;
            word_idx  <= '0;
            blk_bytes <= '0;
            last_q    <= 1'b0;
            if (last_q)                  state <= IDLE;
            else if (remaining == 32'd0) state <= PAD;
            else                         state <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_stage.sv
// Directed self-checking bench for absorb_stage.
module tb_absorb_stage;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    operation_mode = 2'b00;
  logic [31:0]   msg_len = '0;
  logic [63:0]   data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [1343:0] block_out;
  logic          block_valid;
  logic          block_ready = 1'b0;
  logic          last_block;
  logic          busy;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TOPB = 64'h8000_0000_0000_0000;

  absorb_stage #(.WIDTH(64), .RATE(1344)) dut (
    .clk(clk), .rst(rst), .start(start), .operation_mode(operation_mode),
    .msg_len(msg_len), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .block_out(block_out),
    .block_valid(block_valid), .block_ready(block_ready),
    .last_block(last_block), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int k);
    return block_out[k*64 +: 64];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] mode, input logic [31:0] len);
    operation_mode = mode;
    msg_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one word, waiting (bounded) for ready; returns after the accept edge
  task automatic send(input logic [63:0] w);
    int cnt = 0;
    data_in = w;
    data_in_valid = 1'b1;
    while (!data_in_ready && cnt < 50) begin
      step();
      cnt++;
    end
    if (cnt >= 50) chk("send_timeout", {63'b0, data_in_ready}, 64'd1);
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic take_block();
    block_ready = 1'b1;
    step();
    block_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int cnt = 0;
    while (!block_valid && cnt < 50) begin
      step();
      cnt++;
    end
    chk(tag, {63'b0, block_valid}, 64'd1);
  endtask

  // Expect a padding-only block for the given depth
  task automatic chk_pad_only(input string tag, input int depth);
    for (int k = 0; k < 21; k++) begin
      if (k == 0)              chk({tag, "_w0"}, wd(k), 64'h1F);
      else if (k == depth - 1) chk({tag, "_wend"}, wd(k), TOPB);
      else                     chk({tag, "_wz"}, wd(k), 64'h0);
    end
    chk({tag, "_last"}, {63'b0, last_block}, 64'd1);
  endtask

  logic [63:0]   words [0:20];
  logic [1343:0] snap;
  int            unstable;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_valid", {63'b0, block_valid}, 64'd0);
    chk("rst_ready", {63'b0, data_in_ready}, 64'd0);
    chk("rst_last", {63'b0, last_block}, 64'd0);
    chk("rst_w0", wd(0), 64'd0);

    // SHAKE128, empty message
    do_start(M128, 32'd0);
    chk("e_pad_novalid", {63'b0, block_valid}, 64'd0);
    chk("e_pad_busy", {63'b0, busy}, 64'd1);
    step();
    chk("e_valid", {63'b0, block_valid}, 64'd1);
    chk("e_ready0", {63'b0, data_in_ready}, 64'd0);
    chk_pad_only("e", 21);
    take_block();
    chk("e_busy_after", {63'b0, busy}, 64'd0);
    chk("e_valid_after", {63'b0, block_valid}, 64'd0);
    chk("e_cleared", wd(0), 64'd0);

    // SHAKE256, 3 bytes of ones
    do_start(M256, 32'd3);
    send(ONES);
    chk("s3_pad_novalid", {63'b0, block_valid}, 64'd0);
    step();
    chk("s3_valid", {63'b0, block_valid}, 64'd1);
    chk("s3_w0", wd(0), 64'h0000_0000_1FFF_FFFF);
    chk("s3_w1", wd(1), 64'h0);
    chk("s3_w15", wd(15), 64'h0);
    chk("s3_w16", wd(16), TOPB);
    for (int k = 17; k < 21; k++) chk("s3_upper_zero", wd(k), 64'h0);
    chk("s3_last", {63'b0, last_block}, 64'd1);
    take_block();
    chk("s3_idle", {63'b0, busy}, 64'd0);

    // SHAKE256, 135 bytes: padding bytes share byte 135
    do_start(M256, 32'd135);
    for (int k = 0; k < 17; k++) send(ONES);
    chk("s135_pad_novalid", {63'b0, block_valid}, 64'd0);
    step();
    chk("s135_valid", {63'b0, block_valid}, 64'd1);
    for (int k = 0; k < 16; k++) chk("s135_ones", wd(k), ONES);
    chk("s135_w16", wd(16), 64'h9FFF_FFFF_FFFF_FFFF);
    chk("s135_w17", wd(17), 64'h0);
    chk("s135_last", {63'b0, last_block}, 64'd1);
    take_block();
    chk("s135_one_block", {63'b0, busy}, 64'd0);

    // SHAKE128, exactly one rate of data -> data block then padding-only block
    for (int k = 0; k < 21; k++) words[k] = 64'h0123_4567_89AB_CDEF ^ (64'(k) << 8) ^ 64'(k);
    do_start(M128, 32'd168);
    for (int k = 0; k < 21; k++) send(words[k]);
    chk("s168_valid_n1", {63'b0, block_valid}, 64'd1);
    chk("s168_last0", {63'b0, last_block}, 64'd0);
    for (int k = 0; k < 21; k++) chk("s168_word", wd(k), words[k]);
    take_block();
    chk("s168_pad_novalid", {63'b0, block_valid}, 64'd0);
    chk("s168_busy", {63'b0, busy}, 64'd1);
    step();
    chk("s168_pad_valid", {63'b0, block_valid}, 64'd1);
    chk_pad_only("s168p", 21);
    take_block();
    chk("s168_idle", {63'b0, busy}, 64'd0);

    // SHAKE256, 136 bytes with gappy input then long backpressure
    for (int k = 0; k < 17; k++) words[k] = {$urandom, $urandom};
    do_start(M256, 32'd136);
    for (int k = 0; k < 17; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      send(words[k]);
    end
    wait_valid("bp_valid");
    snap = block_out;
    unstable = 0;
    data_in = 64'hDEAD_BEEF_DEAD_BEEF;
    data_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (block_out !== snap || last_block !== 1'b0 || block_valid !== 1'b1
          || data_in_ready !== 1'b0) unstable++;
    end
    data_in_valid = 1'b0;
    chk("bp_stable", 64'(unstable), 64'd0);
    for (int k = 0; k < 17; k++) chk("bp_word", wd(k), words[k]);
    chk("bp_upper", wd(17), 64'h0);
    chk("bp_last0", {63'b0, last_block}, 64'd0);
    take_block();
    wait_valid("bp_pad_valid");
    chk_pad_only("bpp", 17);
    take_block();
    chk("bp_idle", {63'b0, busy}, 64'd0);

    // Reset mid-fill, then a clean 8-byte message
    do_start(M128, 32'd168);
    for (int k = 0; k < 5; k++) send(ONES);
    rst = 1'b1;
    #1;
    chk("ra_busy_async", {63'b0, busy}, 64'd0);
    step();
    chk("ra_busy", {63'b0, busy}, 64'd0);
    chk("ra_ready", {63'b0, data_in_ready}, 64'd0);
    chk("ra_valid", {63'b0, block_valid}, 64'd0);
    chk("ra_last", {63'b0, last_block}, 64'd0);
    chk("ra_w0", wd(0), 64'd0);
    rst = 1'b0;
    step();
    do_start(M128, 32'd8);
    send(64'h1122_3344_5566_7788);
    wait_valid("r8_valid");
    chk("r8_w0", wd(0), 64'h1122_3344_5566_7788);
    chk("r8_w1", wd(1), 64'h1F);
    chk("r8_w2", wd(2), 64'h0);
    chk("r8_w20", wd(20), TOPB);
    chk("r8_last", {63'b0, last_block}, 64'd1);
    take_block();
    chk("r8_idle", {63'b0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
